omi_cache_nway: RTL

//  N-way set-associative, write-through, no-write-allocate cache between a CPU-side OMI slave port and a memory-side OMI master port.

---
 rtl/omi_cache_nway.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/omi_cache_nway.sv
// N-way set-associative write-through / no-write-allocate cache between a CPU OMI slave and a memory OMI master.
// Latency: read hit gives accept + first beat two cycles after the request is sampled; misses add the line fill.
// Backpressure: one transaction at a time; CPU holds its request until o_cache_rdy; memory request held until i_mem_rdy.
module omi_cache_nway #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_SIZE_BITS = 4,
    parameter int SET_SIZE_BITS  = 3,
    parameter int WAYS           = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_flush,
    input  logic                    i_cache_req,
    input  logic [ADDR_WIDTH-1:0]   i_cache_addr,
    input  logic                    i_cache_wen,
    input  logic [DATA_WIDTH/8-1:0] i_cache_ben,
    input  logic [DATA_WIDTH-1:0]   i_cache_data,
    input  logic [7:0]              i_cache_len,
    output logic                    o_cache_rdy,
    output logic                    o_cache_valid,
    output logic [DATA_WIDTH-1:0]   o_cache_data,
    output logic                    o_mem_req,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_wen,
    output logic [DATA_WIDTH/8-1:0] o_mem_ben,
    output logic [DATA_WIDTH-1:0]   o_mem_data,
    output logic [7:0]              o_mem_len,
    input  logic                    i_mem_rdy,
    input  logic                    i_mem_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_data
);

    localparam int BEN_W  = DATA_WIDTH / 8;
    localparam int BYTE_W = $clog2(BEN_W);
    localparam int WORD_W = LINE_SIZE_BITS - BYTE_W;
    localparam int WPL    = 1 << WORD_W;
    localparam int SETS   = 1 << SET_SIZE_BITS;
    localparam int TAG_W  = ADDR_WIDTH - LINE_SIZE_BITS - SET_SIZE_BITS;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL_REQ,
        S_FILL_DATA,
        S_READ_OUT,
        S_WR_REQ
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [BEN_W-1:0]        ben_q, ben_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [WAY_W-1:0]        way_q, way_d;
    logic                    hit_q, hit_d;
    logic                    flush_pend_q, flush_pend_d;

    logic [WAYS-1:0][SETS-1:0]             valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [SETS-1:0][WAY_W-1:0]            rr_q, rr_d;

    logic [DATA_WIDTH-1:0] mem_q [WAYS][SETS][WPL];

    logic [SET_SIZE_BITS-1:0] set_idx;
    logic [TAG_W-1:0]         tag_idx;
    logic [WORD_W-1:0]        word_idx;
    logic [WORD_W-1:0]        rd_widx;
    logic [ADDR_WIDTH-1:0]    line_base;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic [WAYS-1:0]          hit_vec;
    logic [WAY_W-1:0]         hit_way;
    logic                     fill_we;
    logic                     wr_we;

    // Field split of the captured request address; burst beats wrap within the line.
    assign set_idx   = addr_q[LINE_SIZE_BITS +: SET_SIZE_BITS];
    assign tag_idx   = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign word_idx  = addr_q[BYTE_W +: WORD_W];
    assign rd_widx   = word_idx + cnt_q[WORD_W-1:0];
    assign line_base = {addr_q[ADDR_WIDTH-1:LINE_SIZE_BITS], {LINE_SIZE_BITS{1'b0}}};
    assign rd_word   = mem_q[way_q][set_idx][rd_widx];

    // Parallel tag compare across all ways of the addressed set
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][set_idx] && (tag_q[w][set_idx] == tag_idx);
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    // Next-state, array-state updates and all port outputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        ben_d        = ben_q;
        data_d       = data_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        way_d        = way_q;
        hit_d        = hit_q;
        flush_pend_d = flush_pend_q | i_flush;
        valid_d      = valid_q;
        tag_d        = tag_q;
        rr_d         = rr_q;
        fill_we      = 1'b0;
        wr_we        = 1'b0;

        o_cache_rdy   = 1'b0;
        o_cache_valid = 1'b0;
        o_cache_data  = '0;
        o_mem_req     = 1'b0;
        o_mem_addr    = '0;
        o_mem_wen     = 1'b0;
        o_mem_ben     = '0;
        o_mem_data    = '0;
        o_mem_len     = '0;

        case (state_q)
            S_IDLE: begin
                // A flush (new or deferred) takes this cycle; a request waits one more cycle.
                if (flush_pend_q || i_flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (i_cache_req) begin
                    addr_d  = i_cache_addr;
                    wen_d   = i_cache_wen;
                    ben_d   = i_cache_ben;
                    data_d  = i_cache_data;
                    len_d   = i_cache_len;
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                cnt_d = '0;
                if (wen_q) begin
                    hit_d   = |hit_vec;
                    way_d   = hit_way;
                    state_d = S_WR_REQ;
                end else if (|hit_vec) begin
                    way_d   = hit_way;
                    state_d = S_READ_OUT;
                end else begin
                    // Victim is invalidated up front so a half-filled line never looks valid.
                    way_d                            = rr_q[set_idx];
                    valid_d[rr_q[set_idx]][set_idx]  = 1'b0;
                    state_d                          = S_FILL_REQ;
                end
            end

            S_FILL_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = line_base;
                o_mem_len  = 8'(WPL - 1);
                if (i_mem_rdy) begin
                    state_d = S_FILL_DATA;
                end
            end

            S_FILL_DATA: begin
                if (i_mem_valid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == 8'(WPL - 1)) begin
                        valid_d[way_q][set_idx] = 1'b1;
                        tag_d[way_q][set_idx]   = tag_idx;
                        if (rr_q[set_idx] == WAY_W'(WAYS - 1)) begin
                            rr_d[set_idx] = '0;
                        end else begin
                            rr_d[set_idx] = rr_q[set_idx] + 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = S_READ_OUT;
                    end
                end
            end

            S_READ_OUT: begin
                o_cache_rdy   = (cnt_q == 8'd0);
                o_cache_valid = 1'b1;
                o_cache_data  = rd_word;
                cnt_d         = cnt_q + 8'd1;
                if (cnt_q == len_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end

            S_WR_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = addr_q;
                o_mem_wen  = 1'b1;
                o_mem_ben  = ben_q;
                o_mem_data = data_q;
                if (i_mem_rdy) begin
                    o_cache_rdy = 1'b1;
                    wr_we       = hit_q;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control, tag, valid and replacement-pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            ben_q        <= '0;
            data_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            way_q        <= '0;
            hit_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            tag_q        <= '0;
            rr_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            ben_q        <= ben_d;
            data_q       <= data_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            way_q        <= way_d;
            hit_q        <= hit_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            rr_q         <= rr_d;
        end
    end

    // Line storage: fill beats and write-hit byte merges; contents are guarded by the valid bits
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem_q[way_q][set_idx][cnt_q[WORD_W-1:0]] <= i_mem_data;
        end else if (wr_we) begin
            for (int b = 0; b < BEN_W; b++) begin
                if (ben_q[b]) begin
                    mem_q[way_q][set_idx][word_idx][8*b +: 8] <= data_q[8*b +: 8];
                end
            end
        end
    end

endmodule
